// File: rtl/dg0045_nd_display_pkg.sv
// Shared types, defaults and the segment decoder for the DG0045 ND display stage.
package dg0045_disp_pkg;

   localparam int DEF_DIGITS   = 4;
   localparam int DEF_SCAN_DIV = 1024;
   localparam int DEF_BLANK    = 16;
   localparam int DEF_MIN_LOW  = 2;

   typedef enum logic {S_DISP, S_BLANK} scan_state_t;

   // Segment order {g,f,e,d,c,b,a}, active high, lower-case b and d.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dg0045_nd_display_if.sv
// Core-side strobe/data inputs and display-side outputs of the ND display stage.
interface dg0045_nd_display_if #(parameter int DIGITS = 4);

   logic              ena;
   logic              nd_in;
   logic [3:0]        nl_in;
   logic              clear_in;
   logic [6:0]        seg;
   logic [DIGITS-1:0] dig_en;
   logic [7:0]        strobe_cnt;

   modport master (
      output ena, nd_in, nl_in, clear_in,
      input  seg, dig_en, strobe_cnt
   );

   modport slave (
      input  ena, nd_in, nl_in, clear_in,
      output seg, dig_en, strobe_cnt
   );

endinterface

// File: rtl/dg0045_nd_display_capture.sv
// Synchronizes the core's ND strobe and nL bus and qualifies ND pulses by low width.
module dg0045_nd_capture
   import dg0045_disp_pkg::*;
#(
   parameter int MIN_LOW = DEF_MIN_LOW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       nd_in,
   input  logic [3:0] nl_in,
   output logic       accept,
   output logic [3:0] nibble
);

   localparam int LOW_W = $clog2(MIN_LOW + 1);
   localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(MIN_LOW);

   logic             nd_m, nd_s, nd_p;
   logic [3:0]       nl_m, nl_s;
   logic [LOW_W-1:0] low_cnt;

   // Strobe and data share the same two-flop depth so nl_s is aligned with nd_s.
   always_ff @(posedge clk) begin
      if (rst) begin
         nd_m    <= 1'b1;
         nd_s    <= 1'b1;
         nd_p    <= 1'b1;
         nl_m    <= 4'hF;
         nl_s    <= 4'hF;
         low_cnt <= '0;
      end else begin
         nd_m <= nd_in;
         nd_s <= nd_m;
         nd_p <= nd_s;
         nl_m <= nl_in;
         nl_s <= nl_m;
         if (nd_s)
            low_cnt <= '0;
         else if (low_cnt < LOW_MAX)
            low_cnt <= low_cnt + LOW_W'(1);
      end
   end

   // Rising edge of ND after a long-enough low phase; low_cnt still holds that width here.
   assign accept = nd_s && !nd_p && (low_cnt >= LOW_MAX) && ena;
   assign nibble = ~nl_s;

endmodule

// File: rtl/dg0045_nd_display.sv
// DG0045 ND display stage: nibble shift buffer plus multiplexed 7-segment scan with blanking.
module dg0045_nd_display
   import dg0045_disp_pkg::*;
#(
   parameter int DIGITS   = DEF_DIGITS,
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int BLANK    = DEF_BLANK,
   parameter int MIN_LOW  = DEF_MIN_LOW
) (
   input logic                clk,
   input logic                rst,
   dg0045_nd_display_if.slave bus
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0] DISP_END = PRE_W'(SCAN_DIV - BLANK - 1);
   localparam logic [PRE_W-1:0] SLOT_END = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   logic              accept;
   logic [3:0]        nibble;
   logic [3:0]        digit_buf [DIGITS];
   scan_state_t       state;
   logic [IDX_W-1:0]  idx;
   logic [PRE_W-1:0]  presc;

   dg0045_nd_capture #(.MIN_LOW(MIN_LOW)) u_capture (
      .clk    (clk),
      .rst    (rst),
      .ena    (bus.ena),
      .nd_in  (bus.nd_in),
      .nl_in  (bus.nl_in),
      .accept (accept),
      .nibble (nibble)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++) digit_buf[i] <= 4'h0;
         bus.strobe_cnt <= 8'h00;
         bus.seg        <= 7'h00;
         bus.dig_en     <= '0;
         state          <= S_DISP;
         idx            <= '0;
         presc          <= '0;
      end else begin
         // A clear colliding with an accept drops the nibble but still counts the strobe.
         if (accept) bus.strobe_cnt <= bus.strobe_cnt + 8'd1;
         if (bus.ena && bus.clear_in) begin
            for (int i = 0; i < DIGITS; i++) digit_buf[i] <= 4'h0;
         end else if (accept) begin
            for (int i = DIGITS - 1; i > 0; i--) digit_buf[i] <= digit_buf[i-1];
            digit_buf[0] <= nibble;
         end

         if (!bus.ena) begin
            bus.seg    <= 7'h00;
            bus.dig_en <= '0;
         end else begin
            case (state)
               S_DISP: begin
                  bus.dig_en <= DIGITS'(1) << idx;
                  bus.seg    <= hex7(digit_buf[idx]);
                  presc      <= presc + PRE_W'(1);
                  if (presc == DISP_END) state <= S_BLANK;
               end
               S_BLANK: begin
                  bus.dig_en <= '0;
                  bus.seg    <= 7'h00;
                  if (presc == SLOT_END) begin
                     presc <= '0;
                     idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                     state <= S_DISP;
                  end else begin
                     presc <= presc + PRE_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dg0045_nd_display.sv
// Bench for dg0045_nd_display: per-cycle scan scoreboard plus scenario tasks for capture features.
module tb_dg0045_nd_display;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 8;
   localparam int BLANK    = 2;
   localparam int MIN_LOW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dg0045_nd_display_if #(.DIGITS(DIGITS)) bus ();

   dg0045_nd_display #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .MIN_LOW(MIN_LOW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [DIGITS-1:0] dig;
      logic [6:0]        seg;
      bit                chk_seg;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       push_e, pop_e;
   int         errors = 0;
   int         checks = 0;
   logic [3:0] model_buf [DIGITS];
   int         model_cnt = 0;
   bit         seg_chk = 1'b1;
   int         scan_t = 0;
   int         ph, dsel;

   function automatic logic [6:0] ref_hex7(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   // Expected display output for the edge just taken, from the count of enabled cycles.
   always @(posedge clk) begin
      push_e.dig     = '0;
      push_e.seg     = 7'h00;
      push_e.chk_seg = 1'b1;
      if (rst) begin
         scan_t = 0;
      end else if (bus.ena) begin
         ph   = scan_t % SCAN_DIV;
         dsel = (scan_t / SCAN_DIV) % DIGITS;
         if (ph < SCAN_DIV - BLANK) begin
            push_e.dig     = DIGITS'(1) << dsel;
            push_e.seg     = ref_hex7(model_buf[dsel]);
            push_e.chk_seg = seg_chk;
         end
         scan_t++;
      end
      sb_q.push_back(push_e);
   end

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         pop_e = sb_q.pop_front();
         checks++;
         if (bus.dig_en !== pop_e.dig) begin
            errors++;
            $display("FAIL scan_dig_en @%0t got %b want %b", $time, bus.dig_en, pop_e.dig);
         end
         if (pop_e.chk_seg) begin
            checks++;
            if (bus.seg !== pop_e.seg) begin
               errors++;
               $display("FAIL scan_seg @%0t got %h want %h", $time, bus.seg, pop_e.seg);
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < DIGITS; i++) model_buf[i] = 4'h0;
      model_cnt = 0;
   endtask

   task automatic wait_dig(input logic [DIGITS-1:0] pat, output bit found);
      found = 1'b0;
      for (int i = 0; i < 4 * DIGITS * SCAN_DIV; i++) begin
         @(negedge clk);
         if (bus.dig_en === pat) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_strobe(input logic [3:0] nib, input int low, input bit clr);
      @(negedge clk);
      seg_chk    = 1'b0;
      bus.nl_in  = ~nib;
      bus.nd_in  = 1'b0;
      repeat (low) @(negedge clk);
      bus.nd_in  = 1'b1;
      repeat (2) @(negedge clk);
      if (clr) bus.clear_in = 1'b1;
      @(negedge clk);
      bus.clear_in = 1'b0;
      repeat (3) @(negedge clk);
      if (low >= MIN_LOW) begin
         model_cnt = (model_cnt + 1) % 256;
         if (clr) begin
            for (int i = 0; i < DIGITS; i++) model_buf[i] = 4'h0;
         end else begin
            for (int i = DIGITS - 1; i > 0; i--) model_buf[i] = model_buf[i-1];
            model_buf[0] = nib;
         end
      end
      bus.nl_in = 4'hF;
      seg_chk   = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", bus.seg); end
      checks++;
      if (bus.dig_en !== 4'b0000) begin errors++; $display("FAIL reset_dig_en got %b want 0000", bus.dig_en); end
      checks++;
      if (bus.strobe_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.strobe_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_scan();
      int act0, blank;
      bit found;
      act0  = 0;
      blank = 0;
      wait_dig(4'b0001, found);
      checks++;
      if (!found) begin errors++; $display("FAIL scan_start got no digit0 want digit0 active"); end
      for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
         if (bus.dig_en === 4'b0001) act0++;
         if (bus.dig_en === 4'b0000) blank++;
         @(negedge clk);
      end
      checks++;
      if (act0 != SCAN_DIV - BLANK) begin errors++; $display("FAIL scan_active got %0d want %0d", act0, SCAN_DIV - BLANK); end
      checks++;
      if (blank != DIGITS * BLANK) begin errors++; $display("FAIL scan_blank got %0d want %0d", blank, DIGITS * BLANK); end
   endtask

   task automatic test_strobes();
      bit found;
      for (int n = 1; n <= 4; n++) do_strobe(4'(n), 4, 1'b0);
      checks++;
      if (bus.strobe_cnt !== 8'd4) begin errors++; $display("FAIL strobes_cnt got %0d want 4", bus.strobe_cnt); end
      wait_dig(4'b0001, found);
      checks++;
      if (!found || bus.seg !== 7'h66) begin errors++; $display("FAIL strobes_dig0 got %h want 66", bus.seg); end
      wait_dig(4'b1000, found);
      checks++;
      if (!found || bus.seg !== 7'h06) begin errors++; $display("FAIL strobes_dig3 got %h want 06", bus.seg); end
   endtask

   task automatic test_short_pulse();
      bit found;
      do_strobe(4'h9, 1, 1'b0);
      checks++;
      if (bus.strobe_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL short_cnt got %0d want %0d", bus.strobe_cnt, model_cnt); end
      wait_dig(4'b0001, found);
      checks++;
      if (!found || bus.seg !== 7'h66) begin errors++; $display("FAIL short_dig0 got %h want 66", bus.seg); end
   endtask

   task automatic test_clear_accept();
      bit found;
      do_strobe(4'hA, 4, 1'b1);
      checks++;
      if (bus.strobe_cnt !== 8'd5) begin errors++; $display("FAIL clear_cnt got %0d want 5", bus.strobe_cnt); end
      wait_dig(4'b0001, found);
      checks++;
      if (!found || bus.seg !== 7'h3F) begin errors++; $display("FAIL clear_dig0 got %h want 3F", bus.seg); end
      wait_dig(4'b1000, found);
      checks++;
      if (!found || bus.seg !== 7'h3F) begin errors++; $display("FAIL clear_dig3 got %h want 3F", bus.seg); end
   endtask

   task automatic test_ena();
      bit found;
      int run;
      wait_dig(4'b0100, found);
      checks++;
      if (!found) begin errors++; $display("FAIL ena_find got none want digit2"); end
      repeat (2) @(negedge clk);
      bus.ena = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (bus.dig_en !== 4'b0000 || bus.seg !== 7'h00) begin
         errors++; $display("FAIL ena_off got %b/%h want 0000/00", bus.dig_en, bus.seg);
      end
      bus.ena = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.dig_en !== 4'b0100) begin errors++; $display("FAIL ena_resume got %b want 0100", bus.dig_en); end
      run = 0;
      for (int i = 0; i < SCAN_DIV && bus.dig_en === 4'b0100; i++) begin
         run++;
         @(negedge clk);
      end
      checks++;
      if (run != SCAN_DIV - BLANK - 3) begin errors++; $display("FAIL ena_remaining got %0d want %0d", run, SCAN_DIV - BLANK - 3); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 255; n++) do_strobe(4'(n), 2, 1'b0);
      checks++;
      if (bus.strobe_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", bus.strobe_cnt); end
      do_strobe(4'h7, 2, 1'b0);
      checks++;
      if (bus.strobe_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", bus.strobe_cnt); end
   endtask

   task automatic test_reset_mid_strobe();
      bit found;
      do_strobe(4'hC, 3, 1'b0);
      checks++;
      if (bus.strobe_cnt !== 8'd1) begin errors++; $display("FAIL rms_pre_cnt got %0d want 1", bus.strobe_cnt); end
      @(negedge clk);
      seg_chk   = 1'b0;
      bus.nl_in = ~4'h5;
      bus.nd_in = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.seg !== 7'h00 || bus.dig_en !== 4'b0000 || bus.strobe_cnt !== 8'd0) begin
         errors++; $display("FAIL rms_in_reset got %h/%b/%0d want 00/0000/0", bus.seg, bus.dig_en, bus.strobe_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      bus.nd_in = 1'b1;
      repeat (6) @(negedge clk);
      bus.nl_in = 4'hF;
      seg_chk   = 1'b1;
      checks++;
      if (bus.strobe_cnt !== 8'd0) begin errors++; $display("FAIL rms_cnt got %0d want 0", bus.strobe_cnt); end
      wait_dig(4'b0001, found);
      checks++;
      if (!found || bus.seg !== 7'h3F) begin errors++; $display("FAIL rms_dig0 got %h want 3F", bus.seg); end
   endtask

   initial begin
      bus.ena      = 1'b1;
      bus.nd_in    = 1'b1;
      bus.nl_in    = 4'hF;
      bus.clear_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) model_buf[i] = 4'h0;
      test_reset();
      test_scan();
      test_strobes();
      test_short_pulse();
      test_clear_accept();
      test_ena();
      test_wrap();
      test_reset_mid_strobe();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
